mb_psg_bus_sequencer: RTL and testbench
=======================================

Name: mb_psg_bus_sequencer

Overview:
- Decodes the Mockingboard VIA port-B bus-control codes (RESET_n/BDIR/BC1) and port-A data for the left and right PSGs into discrete PSG register-write transactions.
- Arbitrates both sides round-robin onto one shared register-write port, which feeds the shadow register file used by audio-visualisation and save-state logic.
- Sits beside the two VIA/PSG pairs; taps the VIA port outputs only and never drives the PSGs.

Parameters:
- ENABLE, 1'b1, 0 = block inert: no pushes, no outputs beyond reset values.
- FIFO_DEPTH, 2, per-side pending-write buffer depth; power of two, ≥2.

Ports:
- clk_logic  in  1  system logic clock
- reset  in  1  synchronous, active-high reset
- pa_l_i  in  8  left VIA port A output (PSG data bus)
- pb_l_i  in  3  left VIA port B[2:0] = {RESET_n, BDIR, BC1}
- pa_r_i  in  8  right VIA port A output
- pb_r_i  in  3  right VIA port B[2:0]
- wr_valid_o  out  1  write transaction valid
- wr_ready_i  in  1  consumer accepts when valid & ready
- wr_chip_o  out  1  0 = left, 1 = right
- wr_addr_o  out  4  PSG register number
- wr_data_o  out  8  register value
- psg_reset_o  out  2  one-cycle pulse per side; [0] = left, [1] = right
- overflow_o  out  2  sticky per-side drop flag
- overflow_clr_i  in  1  clears both overflow flags

Behaviour:
- Reset: all outputs 0; FIFOs empty; address latches 0 and invalid; pb_prev = 3'b100 (inactive); round-robin pointer = left.
- Per side, registered pb_prev; an event occurs on the cycle where pb_x_i != pb_prev (code entry); held codes never retrigger.
- Code decode (on event):
  - pb[2]=0: PSG reset. psg_reset_o[side] pulses for 1 cycle (cycle after the event), FIFO flushed, latch invalidated. Any further change while pb[2]=0 generates no extra pulse.
  - 3'b111 latch: addr_latch <= pa[3:0]; addr_valid <= (pa[7:4]==0).
  - 3'b110 write: if addr_valid, push {addr_latch, pa} into the FIFO on the event cycle. If addr_valid=0, ignore.
  - 3'b101 read, 3'b100 inactive: no action.
- FIFO full on push: write dropped, overflow_o[side] set at the next edge. overflow_clr_i clears the flags; simultaneous set and clear resolves as set.
- Output stage: a single register. It loads when empty, or when wr_valid_o & wr_ready_i in the same cycle (zero-bubble back-to-back).
  - Source: the non-empty FIFO head; if both are non-empty, the side named by the rr pointer. The pointer then flips to the other side.
  - Latency: write event at edge N pushes; wr_valid_o high after edge N+1 if the stage and that FIFO were empty.
- wr_valid_o and its payload hold stable until accepted; no retraction.
- Simultaneous events on both sides: both pushes happen in the same cycle.
- Push and pop of the same FIFO in one cycle: allowed, including when full (the pop frees the slot, so the push succeeds).
- PSG reset of a side while its entry sits in the output stage: that entry still completes; only FIFO contents are flushed.
- Global reset mid-transaction: wr_valid_o drops at the next edge; the consumer must tolerate this.
- ENABLE=0: events ignored; outputs stay at reset values.

Decomposition:
- Package mb_psg_pkg:
  - enum psg_bus_cmd_t {CMD_INACTIVE=3'b100, CMD_READ=3'b101, CMD_WRITE=3'b110, CMD_LATCH=3'b111}
  - struct psg_wr_t {chip, addr[3:0], data[7:0]}
- Sub-module mb_psg_side_decoder, instantiated twice: edge detection, address latch, FIFO, reset pulse, overflow flag. It exposes head/valid/pop.
- The top level holds the round-robin arbiter and the output stage.

Test Plan:
- Left: latch code with pa=8'h07, then write code with pa=8'h3E, wr_ready_i=1 → one transaction {chip 0, addr 7, data 3E}; wr_valid_o rises 2 edges after the write code is applied and lasts 1 cycle.
- Latch pa=8'h17 then write pa=8'h55 → no transaction (addr invalid). A subsequent latch pa=8'h08 and write pa=8'h0F → {0, 8, 0F}.
- wr_ready_i=0; three left writes (regs 0, 1, 2) → the first is held in the output stage, two fill the FIFO, the fourth write sets overflow_o[0]. Raising ready drains 0, 1, 2 in order; overflow_clr_i clears the flag.
- Both sides write on the same cycle, repeated 4×, ready=1 → chips alternate L, R, L, R… with no lost writes and no idle cycle between them.
- Right side: queue 2 writes with ready=0, then drive pb_r_i=3'b000 → psg_reset_o[1] pulses once; after ready=1 only the entry already in the output stage (if any) emerges.
- Assert reset while wr_valid_o=1 → at the next edge all outputs are 0; a fresh latch+write after reset works normally.

Source files
------------

// File: rtl/mb_psg_pkg.sv
// Shared types for the Mockingboard PSG bus sequencer: VIA port-B bus codes
// and the register-write record carried from the side decoders to the output stage.
package mb_psg_pkg;

  typedef enum logic [2:0] {
    CMD_INACTIVE = 3'b100,
    CMD_READ     = 3'b101,
    CMD_WRITE    = 3'b110,
    CMD_LATCH    = 3'b111
  } psg_bus_cmd_t;

  typedef struct packed {
    logic       chip;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_wr_t;

  localparam int NUM_SIDES = 2;

endpackage

// File: rtl/mb_psg_side_decoder.sv
// One PSG side: detects bus-code entries, tracks the address latch, buffers
// completed register writes and raises the PSG reset pulse / sticky drop flag.
module mb_psg_side_decoder
  import mb_psg_pkg::*;
#(
  parameter bit ENABLE     = 1'b1,
  parameter int FIFO_DEPTH = 2,
  parameter bit SIDE       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pa,
  input  logic [2:0] pb,
  input  logic       pop,
  input  logic       ovf_clr,
  output psg_wr_t    head,
  output logic       head_vld,
  output logic       psg_reset,
  output logic       ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]  r_pb_prev;
  logic [3:0]  r_addr;
  logic        r_addr_vld;
  psg_wr_t     r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_psg_reset;
  logic        r_ovf;

  logic w_event;
  logic w_rst_entry;
  logic w_latch;
  logic w_push_req;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Only a change of code is an event; held codes never retrigger.
  assign w_event     = ENABLE && (pb != r_pb_prev);
  assign w_rst_entry = w_event && !pb[2];
  assign w_latch     = w_event && (pb == CMD_LATCH);
  assign w_push_req  = w_event && (pb == CMD_WRITE) && r_addr_vld;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && !w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb_prev   <= CMD_INACTIVE;
      r_addr      <= '0;
      r_addr_vld  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_psg_reset <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_pb_prev   <= pb;
      // Pulse only on entering reset, not on code changes while already in it.
      r_psg_reset <= w_rst_entry && r_pb_prev[2];
      r_ovf       <= (r_ovf && !ovf_clr) || w_drop;
      if (w_rst_entry) begin
        r_addr_vld <= 1'b0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_latch) begin
          r_addr     <= pa[3:0];
          r_addr_vld <= (pa[7:4] == 4'h0);
        end
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= '{chip: SIDE, addr: r_addr, data: pa};
  end

  assign head      = r_mem[r_rptr[AW-1:0]];
  assign head_vld  = !w_empty;
  assign psg_reset = r_psg_reset;
  assign ovf       = r_ovf;

endmodule

// File: rtl/mb_psg_bus_sequencer.sv
// Mockingboard PSG bus tap: two side decoders arbitrated round-robin into a
// single registered write port feeding the shadow register file.
module mb_psg_bus_sequencer
  import mb_psg_pkg::*;
#(
  parameter bit ENABLE     = 1'b1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk_logic,
  input  logic       reset,
  input  logic [7:0] pa_l_i,
  input  logic [2:0] pb_l_i,
  input  logic [7:0] pa_r_i,
  input  logic [2:0] pb_r_i,
  output logic       wr_valid_o,
  input  logic       wr_ready_i,
  output logic       wr_chip_o,
  output logic [3:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [1:0] psg_reset_o,
  output logic [1:0] overflow_o,
  input  logic       overflow_clr_i
);

  logic [NUM_SIDES-1:0][7:0] w_pa;
  logic [NUM_SIDES-1:0][2:0] w_pb;
  psg_wr_t                   w_head [NUM_SIDES];
  logic [NUM_SIDES-1:0]      w_head_vld;
  logic [NUM_SIDES-1:0]      w_pop;
  logic [NUM_SIDES-1:0]      w_psg_reset;
  logic [NUM_SIDES-1:0]      w_ovf;

  logic    r_valid;
  psg_wr_t r_stage;
  logic    r_rr;

  logic w_load;
  logic w_any;
  logic w_pick;

  assign w_pa = {pa_r_i, pa_l_i};
  assign w_pb = {pb_r_i, pb_l_i};

  for (genvar g = 0; g < NUM_SIDES; g++) begin : g_side
    mb_psg_side_decoder #(
      .ENABLE     (ENABLE),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SIDE       (g[0])
    ) u_dec (
      .clk       (clk_logic),
      .reset     (reset),
      .pa        (w_pa[g]),
      .pb        (w_pb[g]),
      .pop       (w_pop[g]),
      .ovf_clr   (overflow_clr_i),
      .head      (w_head[g]),
      .head_vld  (w_head_vld[g]),
      .psg_reset (w_psg_reset[g]),
      .ovf       (w_ovf[g])
    );
  end

  // Stage reloads when empty or when its current entry is being accepted.
  assign w_load = !r_valid || wr_ready_i;
  assign w_any  = |w_head_vld;
  assign w_pick = (&w_head_vld) ? r_rr : w_head_vld[1];

  always_comb begin
    w_pop = '0;
    if (w_load && w_any) w_pop[w_pick] = 1'b1;
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_stage <= '0;
      r_rr    <= 1'b0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_stage <= w_head[w_pick];
        r_rr    <= !w_pick;
      end
    end
  end

  assign wr_valid_o  = r_valid;
  assign wr_chip_o   = r_stage.chip;
  assign wr_addr_o   = r_stage.addr;
  assign wr_data_o   = r_stage.data;
  assign psg_reset_o = w_psg_reset;
  assign overflow_o  = w_ovf;

endmodule

// File: tb/tb_mb_psg_bus_sequencer.sv
// Directed bench for mb_psg_bus_sequencer: decode, drop/overflow, round-robin
// interleave, PSG reset flush and global reset behaviour.
module tb_mb_psg_bus_sequencer;

  logic       clk_logic = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pa_l_i = '0;
  logic [2:0] pb_l_i = 3'b100;
  logic [7:0] pa_r_i = '0;
  logic [2:0] pb_r_i = 3'b100;
  logic       wr_valid_o;
  logic       wr_ready_i = 1'b0;
  logic       wr_chip_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [1:0] psg_reset_o;
  logic [1:0] overflow_o;
  logic       overflow_clr_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rec_on = 1'b0;
  logic [12:0] rec_q [$];
  int          rec_cyc [$];

  mb_psg_bus_sequencer #(.ENABLE(1'b1), .FIFO_DEPTH(2)) dut (
    .clk_logic      (clk_logic),
    .reset          (reset),
    .pa_l_i         (pa_l_i),
    .pb_l_i         (pb_l_i),
    .pa_r_i         (pa_r_i),
    .pb_r_i         (pb_r_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_chip_o      (wr_chip_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .psg_reset_o    (psg_reset_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk_logic = ~clk_logic;

  task automatic tick();
    @(posedge clk_logic);
    #1;
    cyc++;
    if (rec_on && wr_valid_o) begin
      rec_q.push_back({wr_chip_o, wr_addr_o, wr_data_o});
      rec_cyc.push_back(cyc);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_l(input logic [2:0] pb, input logic [7:0] pa);
    pb_l_i = pb;
    pa_l_i = pa;
  endtask

  task automatic set_r(input logic [2:0] pb, input logic [7:0] pa);
    pb_r_i = pb;
    pa_r_i = pa;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_l(3'b100, 8'h00);
    set_r(3'b100, 8'h00);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", wr_valid_o, 0);
    chk("rst_chip", wr_chip_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_psg_reset", psg_reset_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // Basic latch + write, two-edge latency, one-cycle valid with ready=1
    wr_ready_i = 1'b1;
    set_l(3'b111, 8'h07); tick();
    set_l(3'b110, 8'h3E); tick();
    chk("t1_valid_n1", wr_valid_o, 0);
    set_l(3'b100, 8'h00); tick();
    chk("t1_valid", wr_valid_o, 1);
    chk("t1_chip", wr_chip_o, 0);
    chk("t1_addr", wr_addr_o, 4'h7);
    chk("t1_data", wr_data_o, 8'h3E);
    tick();
    chk("t1_valid_drop", wr_valid_o, 0);

    // Invalid address (upper nibble set) is ignored; valid one follows
    set_l(3'b111, 8'h17); tick();
    set_l(3'b110, 8'h55); tick();
    set_l(3'b100, 8'h00); tick();
    tick();
    chk("t2_invalid_none", wr_valid_o, 0);
    set_l(3'b111, 8'h08); tick();
    set_l(3'b110, 8'h0F); tick();
    set_l(3'b100, 8'h00); tick();
    chk("t2_valid", wr_valid_o, 1);
    chk("t2_addr", wr_addr_o, 4'h8);
    chk("t2_data", wr_data_o, 8'h0F);

    // Backpressure: stage + full FIFO, fourth write dropped
    do_reset();
    wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_l(3'b111, 8'(i)); tick();
      set_l(3'b110, 8'hA0 + 8'(i)); tick();
    end
    set_l(3'b111, 8'h03); tick();
    chk("t3_ovf_pre", overflow_o, 2'b00);
    set_l(3'b110, 8'hA3); tick();
    chk("t3_ovf_set", overflow_o, 2'b01);
    chk("t3_hold_valid", wr_valid_o, 1);
    chk("t3_hold_addr", wr_addr_o, 4'h0);
    chk("t3_hold_data", wr_data_o, 8'hA0);
    set_l(3'b100, 8'h00);
    wr_ready_i = 1'b1;
    tick();
    chk("t3_d1_addr", wr_addr_o, 4'h1);
    chk("t3_d1_data", wr_data_o, 8'hA1);
    tick();
    chk("t3_d2_valid", wr_valid_o, 1);
    chk("t3_d2_data", wr_data_o, 8'hA2);
    tick();
    chk("t3_drained", wr_valid_o, 0);
    chk("t3_ovf_sticky", overflow_o, 2'b01);
    overflow_clr_i = 1'b1; tick();
    overflow_clr_i = 1'b0;
    chk("t3_ovf_clr", overflow_o, 2'b00);

    // Simultaneous writes on both sides: strict L/R alternation, no bubbles
    do_reset();
    wr_ready_i = 1'b1;
    rec_q.delete();
    rec_cyc.delete();
    rec_on = 1'b1;
    set_l(3'b111, 8'h05);
    set_r(3'b111, 8'h06);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_l(3'b110, 8'h10 + 8'(i));
      set_r(3'b110, 8'h20 + 8'(i));
      tick();
      set_l(3'b100, 8'h00);
      set_r(3'b100, 8'h00);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    rec_on = 1'b0;
    chk("t4_count", rec_q.size(), 8);
    if (rec_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        logic [12:0] exp_w;
        exp_w = (k % 2 == 0) ? {1'b0, 4'h5, 8'h10 + 8'(k / 2)}
                             : {1'b1, 4'h6, 8'h20 + 8'(k / 2)};
        chk($sformatf("t4_entry%0d", k), rec_q[k], exp_w);
      end
      chk("t4_no_bubble", rec_cyc[7] - rec_cyc[0], 7);
    end

    // Right-side PSG reset flushes the FIFO but not the output stage
    do_reset();
    wr_ready_i = 1'b0;
    set_r(3'b111, 8'h02); tick();
    set_r(3'b110, 8'hB1); tick();
    set_r(3'b111, 8'h03); tick();
    set_r(3'b110, 8'hB2); tick();
    chk("t5_pulse_pre", psg_reset_o, 2'b00);
    set_r(3'b000, 8'h00); tick();
    chk("t5_pulse", psg_reset_o, 2'b10);
    chk("t5_stage_chip", wr_chip_o, 1);
    chk("t5_stage_data", wr_data_o, 8'hB1);
    set_r(3'b001, 8'h00); tick();
    chk("t5_pulse_once", psg_reset_o, 2'b00);
    tick();
    chk("t5_no_repulse", psg_reset_o, 2'b00);
    set_r(3'b100, 8'h00);
    wr_ready_i = 1'b1;
    chk("t5_held_valid", wr_valid_o, 1);
    chk("t5_held_addr", wr_addr_o, 4'h2);
    tick();
    chk("t5_flushed", wr_valid_o, 0);
    tick();
    chk("t5_flushed2", wr_valid_o, 0);

    // Global reset while valid, then normal operation resumes
    do_reset();
    wr_ready_i = 1'b0;
    set_l(3'b111, 8'h09); tick();
    set_l(3'b110, 8'hC3); tick();
    tick();
    chk("t6_valid_pre", wr_valid_o, 1);
    reset = 1'b1;
    set_l(3'b100, 8'h00);
    tick();
    chk("t6_rst_valid", wr_valid_o, 0);
    chk("t6_rst_payload", {wr_chip_o, wr_addr_o, wr_data_o}, 0);
    reset = 1'b0;
    wr_ready_i = 1'b1;
    set_l(3'b111, 8'h0A); tick();
    set_l(3'b110, 8'hC4); tick();
    set_l(3'b100, 8'h00); tick();
    chk("t6_after_valid", wr_valid_o, 1);
    chk("t6_after_payload", {wr_chip_o, wr_addr_o, wr_data_o}, {1'b0, 4'hA, 8'hC4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
